mem_arbiter: RTL
================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter TIMEOUT, default 16: maximum cycles a granted transfer may wait for s_ready.
REQ-002 Parameter ERR_RDATA, default 32'hDEAD_BEEF: read data returned on a timed-out transfer.
REQ-003 clk  in  1  clock; all state changes on the rising edge.
REQ-004 reset_n  in  1  reset, synchronous, active-low.
REQ-005 m0_valid / m1_valid  in  1  requester 0/1 transfer request, held until the matching ready.
REQ-006 m0_ready / m1_ready  out  1  requester 0/1 transfer complete, single-cycle pulse.
REQ-007 m0_addr / m1_addr  in  32  requester byte address.
REQ-008 m0_wdata / m1_wdata  in  32  requester write data.
REQ-009 m0_wstrb / m1_wstrb  in  4  requester strobe: 4'b0000 is a read, nonzero is a write.
REQ-010 m0_rdata / m1_rdata  out  32  requester read data, valid only while the matching ready is 1.
REQ-011 s_valid  out  1  shared-memory request.
REQ-012 s_ready  in  1  shared-memory completion pulse.
REQ-013 s_addr / s_wdata / s_wstrb  out  32/32/4  shared-memory request fields.
REQ-014 s_rdata  in  32  shared-memory read data, valid with s_ready.
REQ-015 grant  out  2  one-hot current owner: 2'b01 is requester 0, 2'b10 is requester 1, 2'b00 is idle.
REQ-016 bus_err  out  1  single-cycle pulse when a transfer times out.

Function
REQ-017 FSM states: IDLE, GRANT0, GRANT1.
REQ-018 IDLE, no request: stay in IDLE.
REQ-019 IDLE, exactly one valid: go to the matching GRANTn on the next edge.
REQ-020 IDLE, both valid: grant the requester not granted last (round-robin via a last_grant bit).
REQ-021 Arbitration latency is one cycle: s_valid rises the cycle after the winning valid is first sampled in IDLE.
REQ-022 On the IDLE->GRANTn edge, capture the winner's addr, wdata and wstrb into registers.
REQ-023 s_addr, s_wdata and s_wstrb are driven from the captured registers and are stable for the whole grant.
REQ-024 s_valid = 1 exactly while in GRANT0 or GRANT1, registered and glitch-free.
REQ-025 GRANTn with s_ready = 1: mn_ready = 1 in the same cycle (combinational), mn_rdata = s_rdata, next state IDLE, last_grant <= n.
REQ-026 Non-granted requester: ready = 0 always; rdata may follow s_rdata and is don't-care.
REQ-027 Every completion returns through IDLE, so s_valid is 0 for at least one cycle between transfers.
REQ-028 A requester pending during another requester's grant is served next; maximum wait is one full transfer.
REQ-029 Timeout counter: cleared on grant entry, +1 per GRANTn cycle without s_ready.
REQ-030 Timeout fires when the count reaches TIMEOUT-1 with s_ready still 0; width is clog2(TIMEOUT)+1 and the counter never wraps.
REQ-031 On timeout: mn_ready = 1, mn_rdata = ERR_RDATA, bus_err = 1 for that cycle, next state IDLE, last_grant <= n.
REQ-032 s_ready coincident with the timeout cycle counts as normal completion: s_rdata is returned and bus_err = 0.
REQ-033 s_ready arriving while in IDLE is ignored and produces no requester ready.
REQ-034 A requester dropping valid mid-grant does not abort; the transfer completes and ready is still pulsed.

Reset
REQ-035 reset_n = 0 at an edge: state = IDLE, last_grant = 1 (requester 0 wins the first tie), counter = 0, captured registers = 0.
REQ-036 During and after reset: s_valid = 0, grant = 2'b00, m0_ready = m1_ready = 0, bus_err = 0.
REQ-037 Reset asserted mid-grant abandons the transfer with no ready pulse to either requester.

Verification
REQ-038 Single read: m0 read at 0x10, slave with 3 wait states returning 0x12345678 -> s_valid from cycle 1, m0_ready and m0_rdata = 0x12345678 at cycle 4, s_valid = 0 at cycle 5.
REQ-039 Tie: m0 and m1 valid in the same cycle after reset -> m0 served first, then m1; next tie -> m0 first again; grant sequence 01, 00, 10, 00.
REQ-040 Write: m1 writes 0xCAFEF00D to 0x40 with wstrb 4'b1111 -> s_addr = 0x40, s_wdata = 0xCAFEF00D, s_wstrb = 4'b1111 stable for the whole grant; exactly one m1_ready pulse.
REQ-041 Timeout: slave never asserts ready, TIMEOUT = 16 -> m0_ready with rdata 0xDEADBEEF and bus_err = 1 in the 16th grant cycle; a late s_ready in IDLE is ignored.
REQ-042 Reset mid-operation: reset_n = 0 in the 2nd grant cycle -> next cycle s_valid = 0, grant = 00, no ready pulse; a fresh m1 request is then served normally.
REQ-043 Boundary: s_ready in exactly the timeout cycle -> normal data returned, bus_err = 0.

Source files
------------

// File: rtl/mem_arbiter.sv
// Two-requester round-robin arbiter onto a single shared memory port.
// Each grant holds until s_ready or a TIMEOUT-cycle watchdog expires, then returns through IDLE.
module mem_arbiter #(
  parameter int unsigned TIMEOUT   = 16,
  parameter logic [31:0] ERR_RDATA = 32'hDEAD_BEEF
) (
  input  logic        clk,
  input  logic        reset_n,

  input  logic        m0_valid,
  output logic        m0_ready,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  input  logic [3:0]  m0_wstrb,
  output logic [31:0] m0_rdata,

  input  logic        m1_valid,
  output logic        m1_ready,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  input  logic [3:0]  m1_wstrb,
  output logic [31:0] m1_rdata,

  output logic        s_valid,
  input  logic        s_ready,
  output logic [31:0] s_addr,
  output logic [31:0] s_wdata,
  output logic [3:0]  s_wstrb,
  input  logic [31:0] s_rdata,

  output logic [1:0]  grant,
  output logic        bus_err
);

  localparam int unsigned   CW       = $clog2(TIMEOUT) + 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  // Encoding doubles as the one-hot grant vector.
  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    GRANT0 = 2'b01,
    GRANT1 = 2'b10
  } state_t;

  state_t        state_q, state_d;
  logic          last_grant_q, last_grant_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0]   addr_q, addr_d;
  logic [31:0]   wdata_q, wdata_d;
  logic [3:0]    wstrb_q, wstrb_d;

  logic busy;
  logic timeout;
  logic done;

  assign busy    = (state_q != IDLE);
  assign timeout = busy && !s_ready && (cnt_q == CNT_LAST);
  assign done    = busy && (s_ready || timeout);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      cnt_q        <= '0;
      addr_q       <= '0;
      wdata_q      <= '0;
      wstrb_q      <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      cnt_q        <= cnt_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      wstrb_q      <= wstrb_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    cnt_d        = cnt_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    wstrb_d      = wstrb_q;
    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        // On a tie, requester 0 wins only if requester 1 was served last.
        if (m0_valid && (!m1_valid || last_grant_q)) begin
          state_d = GRANT0;
          addr_d  = m0_addr;
          wdata_d = m0_wdata;
          wstrb_d = m0_wstrb;
        end else if (m1_valid) begin
          state_d = GRANT1;
          addr_d  = m1_addr;
          wdata_d = m1_wdata;
          wstrb_d = m1_wstrb;
        end
      end
      GRANT0, GRANT1: begin
        if (done) begin
          state_d      = IDLE;
          last_grant_d = (state_q == GRANT1);
          cnt_d        = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign grant   = state_q;
  assign s_valid = busy;
  assign s_addr  = addr_q;
  assign s_wdata = wdata_q;
  assign s_wstrb = wstrb_q;

  // Completions are masked while reset_n is low so an abandoned grant never pulses ready.
  assign m0_ready = reset_n && (state_q == GRANT0) && done;
  assign m1_ready = reset_n && (state_q == GRANT1) && done;
  assign bus_err  = reset_n && timeout;

  assign m0_rdata = s_ready ? s_rdata : ERR_RDATA;
  assign m1_rdata = s_ready ? s_rdata : ERR_RDATA;

endmodule
